// File: rtl/mac_window_accum.sv
// Multi-lane multiply-accumulate over a fixed window of beats, with a valid/ready hold register.
// Stage1 registers the lane product sum; stage2 accumulates and hands finished windows to hold.
module mac_window_accum #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned LANES  = 1,
    parameter int unsigned WINDOW = 9,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned SAT    = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*DATA_W-1:0]      x,
    input  logic [LANES*DATA_W-1:0]      y,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_data,
    output logic                         out_ovf,
    output logic [$clog2(WINDOW+1)-1:0]  beat_cnt
);

    localparam int unsigned CNT_W  = $clog2(WINDOW + 1);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
    localparam int unsigned WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

    logic                s1_valid_q, s1_last_q;
    logic [SUM_W-1:0]    s1_sum_q;
    logic [ACC_W-1:0]    acc_q;
    logic                sticky_q;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic                out_valid_q, out_ovf_q;
    logic [ACC_W-1:0]    hold_q;

    logic [PROD_W-1:0]   prod [LANES];
    logic [SUM_W-1:0]    lane_sum;
    logic                s1_adv, accept, hold_load;
    logic [CNT_W-1:0]    cnt_base, cnt_next;
    logic                beat_last;
    logic [WIDE_W-1:0]   acc_wide;
    logic                step_ovf;
    logic [ACC_W-1:0]    sat_val, acc_next;

    function automatic logic [PROD_W-1:0] ext_op(input logic [DATA_W-1:0] v);
        if (SIGNED != 0) return PROD_W'($signed(v));
        return PROD_W'(v);
    endfunction

    always_comb begin
        lane_sum = '0;
        for (int n = 0; n < int'(LANES); n++) begin
            prod[n] = ext_op(x[n*DATA_W +: DATA_W]) * ext_op(y[n*DATA_W +: DATA_W]);
            if (SIGNED != 0) lane_sum = lane_sum + SUM_W'($signed(prod[n]));
            else             lane_sum = lane_sum + SUM_W'(prod[n]);
        end
    end

    // A last beat may only leave stage1 when the hold register can take its result.
    assign s1_adv    = s1_valid_q & ~(s1_last_q & out_valid_q & ~out_ready);
    assign in_ready  = rst_n & (~s1_valid_q | s1_adv);
    assign accept    = in_valid & in_ready;
    assign hold_load = s1_valid_q & s1_adv & s1_last_q & ~clear;

    always_comb begin
        cnt_base  = clear ? '0 : beat_cnt_q;
        beat_last = (cnt_base == LAST_CNT);
        cnt_next  = cnt_base;
        if (accept) cnt_next = beat_last ? '0 : cnt_base + CNT_W'(1);
    end

    // Headroom above ACC_W makes both the signed and unsigned overflow tests exact.
    always_comb begin
        if (SIGNED != 0) begin
            acc_wide = WIDE_W'($signed(acc_q)) + WIDE_W'($signed(s1_sum_q));
            step_ovf = ~(&acc_wide[WIDE_W-1:ACC_W-1]) & (|acc_wide[WIDE_W-1:ACC_W-1]);
            sat_val  = acc_wide[WIDE_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_wide = WIDE_W'(acc_q) + WIDE_W'(s1_sum_q);
            step_ovf = |acc_wide[WIDE_W-1:ACC_W];
            sat_val  = '1;
        end
        acc_next = (step_ovf && (SAT != 0)) ? sat_val : acc_wide[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sum_q    <= '0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
            hold_q      <= '0;
        end else begin
            beat_cnt_q <= cnt_next;

            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_last_q  <= beat_last;
                s1_sum_q   <= lane_sum;
            end else if (clear) begin
                s1_valid_q <= 1'b0;
                s1_last_q  <= 1'b0;
                s1_sum_q   <= '0;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (clear) begin
                acc_q    <= '0;
                sticky_q <= 1'b0;
            end else if (s1_valid_q && s1_adv) begin
                if (s1_last_q) begin
                    acc_q     <= '0;
                    sticky_q  <= 1'b0;
                    hold_q    <= acc_next;
                    out_ovf_q <= sticky_q | step_ovf;
                end else begin
                    acc_q    <= acc_next;
                    sticky_q <= sticky_q | step_ovf;
                end
            end

            if (hold_load)      out_valid_q <= 1'b1;
            else if (out_ready) out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = hold_q;
    assign out_ovf   = out_ovf_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mac_window_accum.sv
// Bench for mac_window_accum: six parameterisations share one stimulus stream and are each
// scored against a window-level arithmetic model with a queue of expected results.
module tb_mac_window_accum;

    localparam int NI = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clear, in_valid, out_ready;
    logic [31:0] xs, ys;

    logic        ir0, ir1, ir2, ir3, ir4, ir5;
    logic        ov0, ov1, ov2, ov3, ov4, ov5;
    logic        oo0, oo1, oo2, oo3, oo4, oo5;
    logic [31:0] od0, od1, od2, od3;
    logic [15:0] od4, od5;
    logic [3:0]  bc0;
    logic [2:0]  bc1;
    logic [1:0]  bc2, bc3, bc4, bc5;

    mac_window_accum #(.DATA_W(8), .ACC_W(32), .LANES(1), .WINDOW(9), .SIGNED(0), .SAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir0),
        .x(xs[7:0]), .y(ys[7:0]), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_ovf(oo0), .beat_cnt(bc0));
    mac_window_accum #(.DATA_W(8), .ACC_W(32), .LANES(1), .WINDOW(7), .SIGNED(0), .SAT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir1),
        .x(xs[7:0]), .y(ys[7:0]), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_ovf(oo1), .beat_cnt(bc1));
    mac_window_accum #(.DATA_W(8), .ACC_W(32), .LANES(4), .WINDOW(2), .SIGNED(0), .SAT(0)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
        .x(xs), .y(ys), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .out_ovf(oo2), .beat_cnt(bc2));
    mac_window_accum #(.DATA_W(8), .ACC_W(32), .LANES(1), .WINDOW(2), .SIGNED(1), .SAT(0)) u3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir3),
        .x(xs[7:0]), .y(ys[7:0]), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
        .out_ovf(oo3), .beat_cnt(bc3));
    mac_window_accum #(.DATA_W(8), .ACC_W(16), .LANES(1), .WINDOW(2), .SIGNED(0), .SAT(1)) u4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir4),
        .x(xs[7:0]), .y(ys[7:0]), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .out_ovf(oo4), .beat_cnt(bc4));
    mac_window_accum #(.DATA_W(8), .ACC_W(16), .LANES(1), .WINDOW(2), .SIGNED(0), .SAT(0)) u5 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(ir5),
        .x(xs[7:0]), .y(ys[7:0]), .out_valid(ov5), .out_ready(out_ready), .out_data(od5),
        .out_ovf(oo5), .beat_cnt(bc5));

    int c_win[NI]   = '{9, 7, 2, 2, 2, 2};
    int c_acc[NI]   = '{32, 32, 32, 32, 16, 16};
    int c_lanes[NI] = '{1, 1, 4, 1, 1, 1};
    bit c_sgn[NI]   = '{0, 0, 0, 1, 0, 0};
    bit c_sat[NI]   = '{0, 0, 0, 0, 1, 0};

    // Model: running window total, plus a FIFO of finished windows awaiting delivery.
    longint      m_acc[NI];
    bit          m_sticky[NI];
    int          m_cnt[NI];
    logic [63:0] q_data[NI][8];
    bit          q_ovf[NI][8];
    int          q_cyc[NI][8];
    int          q_head[NI], q_cnt[NI];
    bit          q_seen[NI];
    logic [63:0] last_out[NI];
    bit          last_ovf[NI];
    int          n_out[NI];

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;
    bit lat_chk   = 1'b1;

    task automatic check(input string tag, input int i, input logic [63:0] got,
                         input logic [63:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, got, exp);
        end
    endtask

    function automatic longint beat_sum(input int i, input logic [31:0] xv, input logic [31:0] yv);
        longint s = 0;
        logic [7:0] a, b;
        for (int l = 0; l < c_lanes[i]; l++) begin
            a = xv[l*8 +: 8];
            b = yv[l*8 +: 8];
            if (c_sgn[i]) s += longint'($signed(a)) * longint'($signed(b));
            else          s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    task automatic observe(input int i, input logic r_ir, input logic r_ov, input logic r_oo,
                           input logic [31:0] r_od, input logic [3:0] r_bc);
        int h;
        longint t, hi, lo;
        bit ovf;
        logic [63:0] mask;
        mask = (64'd1 << c_acc[i]) - 64'd1;
        check("known", i, {63'd0, $isunknown({r_ir, r_ov, r_oo, r_od, r_bc})}, 64'd0);
        check("in_ready", i, {63'd0, r_ir},
              {63'd0, (rst_n === 1'b1) && (q_cnt[i] < 2 || out_ready === 1'b1)});
        check("beat_cnt", i, {60'd0, r_bc}, 64'(m_cnt[i]));
        if (r_ov === 1'b1) begin
            check("out_pending", i, {63'd0, q_cnt[i] != 0}, 64'd1);
            if (q_cnt[i] != 0) begin
                h = q_head[i];
                check("out_data", i, {32'd0, r_od}, q_data[i][h]);
                check("out_ovf", i, {63'd0, r_oo}, {63'd0, q_ovf[i][h]});
                if (lat_chk && !q_seen[i]) check("latency", i, 64'(cyc - q_cyc[i][h]), 64'd2);
                q_seen[i] = 1'b1;
                if (out_ready === 1'b1) begin
                    last_out[i] = {32'd0, r_od};
                    last_ovf[i] = r_oo;
                    n_out[i]++;
                    q_head[i] = (h + 1) % 8;
                    q_cnt[i]--;
                    q_seen[i] = 1'b0;
                end
            end
        end
        if (rst_n !== 1'b1) begin
            q_cnt[i] = 0; q_seen[i] = 1'b0; m_acc[i] = 0; m_sticky[i] = 1'b0; m_cnt[i] = 0;
            return;
        end
        if (clear) begin
            m_acc[i] = 0; m_sticky[i] = 1'b0; m_cnt[i] = 0;
        end
        if (in_valid && r_ir === 1'b1) begin
            hi  = c_sgn[i] ? (64'sd1 <<< (c_acc[i] - 1)) - 1 : (64'sd1 <<< c_acc[i]) - 1;
            lo  = c_sgn[i] ? -(64'sd1 <<< (c_acc[i] - 1)) : 64'sd0;
            t   = m_acc[i] + beat_sum(i, xs, ys);
            ovf = (t > hi) || (t < lo);
            if (ovf) begin
                if (c_sat[i]) t = (t > hi) ? hi : lo;
                else begin
                    t = t & longint'(mask);
                    if (c_sgn[i] && t > hi) t -= (64'sd1 <<< c_acc[i]);
                end
            end
            m_acc[i] = t;
            m_sticky[i] |= ovf;
            m_cnt[i]++;
            if (m_cnt[i] == c_win[i]) begin
                h = (q_head[i] + q_cnt[i]) % 8;
                q_data[i][h] = 64'(m_acc[i]) & mask;
                q_ovf[i][h]  = m_sticky[i];
                q_cyc[i][h]  = cyc;
                q_cnt[i]++;
                m_acc[i] = 0; m_sticky[i] = 1'b0; m_cnt[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe(0, ir0, ov0, oo0, od0, bc0);
        observe(1, ir1, ov1, oo1, od1, {1'b0, bc1});
        observe(2, ir2, ov2, oo2, od2, {2'b0, bc2});
        observe(3, ir3, ov3, oo3, od3, {2'b0, bc3});
        observe(4, ir4, ov4, oo4, {16'd0, od4}, {2'b0, bc4});
        observe(5, ir5, ov5, oo5, {16'd0, od5}, {2'b0, bc5});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic beat(input logic [31:0] xv, input logic [31:0] yv);
        in_valid = 1'b1; xs = xv; ys = yv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        for (int i = 0; i < NI; i++) check("drained", i, 64'(q_cnt[i]), 64'd0);
    endtask

    task automatic check_zero();
        check("rst_state", 0, {ov0, oo0, od0, bc0}, 64'd0);
        check("rst_state", 1, {ov1, oo1, od1, bc1}, 64'd0);
        check("rst_state", 2, {ov2, oo2, od2, bc2}, 64'd0);
        check("rst_state", 3, {ov3, oo3, od3, bc3}, 64'd0);
        check("rst_state", 4, {ov4, oo4, od4, bc4}, 64'd0);
        check("rst_state", 5, {ov5, oo5, od5, bc5}, 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        check_zero();
        rst_n = 1'b1;
    endtask

    int base;

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1; xs = '0; ys = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Signed window: -128*127 + (-1)*(-1)
        beat(32'h80, 32'h7F);
        beat(32'hFF, 32'hFF);
        drain();
        check("signed_win", 3, last_out[3], 64'hFFFFC081);
        do_reset();

        // Two back-to-back all-FF windows: 4-lane sum and 16-bit saturate / wrap
        base = n_out[2];
        repeat (4) beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        check("lanes4_sum", 2, last_out[2], 64'd520200);
        check("lanes4_count", 2, 64'(n_out[2] - base), 64'd2);
        check("sat_data", 4, last_out[4], 64'hFFFF);
        check("sat_ovf", 4, {63'd0, last_ovf[4]}, 64'd1);
        check("wrap_data", 5, last_out[5], 64'hFC02);
        check("wrap_ovf", 5, {63'd0, last_ovf[5]}, 64'd1);
        do_reset();

        // Seven-beat unsigned window
        base = n_out[1];
        beat(32'h7F, 32'h7F); beat(32'hAA, 32'h55); beat(32'hAF, 32'h5D); beat(32'hEA, 32'h50);
        beat(32'h7F, 32'h00); beat(32'h00, 32'h7F); beat(32'hFF, 32'hFF);
        drain();
        check("win7_data", 1, last_out[1], 64'h0001FE27);
        check("win7_ovf", 1, {63'd0, last_ovf[1]}, 64'd0);
        check("win7_count", 1, 64'(n_out[1] - base), 64'd1);
        do_reset();

        // clear after 3 beats, then a full window
        base = n_out[0];
        repeat (3) beat(32'h01, 32'h01);
        clear = 1'b1; tick(); clear = 1'b0;
        repeat (9) beat(32'h01, 32'h01);
        drain();
        check("clear_data", 0, last_out[0], 64'd9);
        check("clear_count", 0, 64'(n_out[0] - base), 64'd1);

        // clear coinciding with an accepted beat: that beat opens the new window
        base = n_out[0];
        repeat (2) beat(32'h01, 32'h01);
        clear = 1'b1; beat(32'h01, 32'h01); clear = 1'b0;
        repeat (8) beat(32'h01, 32'h01);
        drain();
        check("clear_beat_data", 0, last_out[0], 64'd9);
        check("clear_beat_count", 0, 64'(n_out[0] - base), 64'd1);

        // Reset mid-window discards the partial sum
        base = n_out[0];
        repeat (4) beat(32'h05, 32'h07);
        do_reset();
        repeat (9) beat(32'h01, 32'h01);
        drain();
        check("post_rst_data", 0, last_out[0], 64'd9);
        check("post_rst_count", 0, 64'(n_out[0] - base), 64'd1);

        // Backpressure: stream with out_ready low, then release
        do_reset();
        lat_chk = 1'b0;
        base = n_out[3];
        out_ready = 1'b0; in_valid = 1'b1;
        repeat (8) begin
            xs = $urandom; ys = $urandom;
            tick();
        end
        check("bp_stall", 3, {63'd0, ir3}, 64'd0);
        out_ready = 1'b1;
        repeat (3) begin
            xs = $urandom; ys = $urandom;
            tick();
        end
        drain();
        check("bp_count", 3, 64'(n_out[3] - base), 64'd3);

        // Random traffic with random backpressure
        do_reset();
        repeat (400) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            xs = $urandom; ys = $urandom;
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
